// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: captures 128-bit AES ciphertext blocks on the core's
// done pulse, holds them in a DEPTH-entry block FIFO and streams them out
// one byte per transfer with a last-byte marker on byte 15.
//
// Output handshake: a byte moves when out_valid && out_ready at a rising
// edge; while out_valid=1 and no transfer happens, out_data/out_last hold
// and out_valid stays high; out_ready has no effect while out_valid=0.
module aes_ct_serializer #(
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [127:0]                 ct_in,
   input  logic                         ct_done,
   output logic [7:0]                   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   blk_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [127:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [3:0]    r_idx;
   logic          r_overflow;

   logic [127:0]  w_head;
   logic          w_valid;
   logic          w_xfer;
   logic          w_pop;
   logic          w_slot;
   logic          w_push;
   logic [3:0]    w_sel;
   logic [7:0]    w_byte;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_head  = r_mem[r_rd_ptr];
   assign w_valid = (r_count != '0);
   assign w_xfer  = w_valid && out_ready;
   assign w_pop   = w_xfer && (r_idx == 4'd15);
   // A full buffer still accepts a block when its head leaves this cycle.
   assign w_slot  = (r_count < CW'(DEPTH)) || w_pop;
   assign w_push  = ct_done && w_slot;

   // Select the current byte of the head block in the configured order.
   always_comb begin
      w_sel  = MSB_FIRST ? (4'd15 - r_idx) : r_idx;
      w_byte = w_head[{w_sel, 3'b000} +: 8];
   end

   assign out_valid = w_valid;
   assign out_data  = w_valid ? w_byte : 8'h00;
   assign out_last  = w_valid && (r_idx == 4'd15);
   assign overflow  = r_overflow;
   assign blk_count = r_count;

   // Block storage; contents are only observed through a nonzero count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= ct_in;
      end
   end

   // Pointers, occupancy, byte index and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_idx      <= 4'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (ct_done && !w_slot) begin
            r_overflow <= 1'b1;
         end
         if (w_xfer) begin
            r_idx <= r_idx + 4'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: two instances (MSB-first and LSB-first)
// share all inputs and run in lockstep; a scoreboard queue holds the
// expected byte pairs and a negedge monitor checks every transfer.
module tb_aes_ct_serializer;

   logic         clk;
   logic         rst_n;
   logic [127:0] ct_in;
   logic         ct_done;
   logic         out_ready;

   logic [7:0]   m_data, l_data;
   logic         m_valid, l_valid;
   logic         m_last, l_last;
   logic         m_ovf, l_ovf;
   logic [1:0]   m_cnt, l_cnt;

   // {lsb_last, lsb_data, msb_last, msb_data}
   logic [17:0]  exp_q[$];

   int n_cmp  = 0;
   int n_err  = 0;
   int n_xfer = 0;

   localparam logic [127:0] BLK_K = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] BLK_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] BLK_B = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
   localparam logic [127:0] BLK_C = 128'hdeadbeefcafef00d0123456789abcdef;

   aes_ct_serializer #(.DEPTH(2), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ct_in(ct_in), .ct_done(ct_done),
      .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
      .out_last(m_last), .overflow(m_ovf), .blk_count(m_cnt)
   );

   aes_ct_serializer #(.DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .ct_in(ct_in), .ct_done(ct_done),
      .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
      .out_last(l_last), .overflow(l_ovf), .blk_count(l_cnt)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void push_block(input logic [127:0] blk);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({(i == 15), blk[8*i +: 8], (i == 15), blk[127-8*i -: 8]});
      end
   endfunction

   // Driver: one-cycle ct_done pulse; called just after a rising edge.
   task automatic send_block(input logic [127:0] blk, input bit expect_cap);
      ct_in   = blk;
      ct_done = 1'b1;
      if (expect_cap) push_block(blk);
      @(posedge clk); #1;
      ct_done = 1'b0;
   endtask

   // Wait until the scoreboard is empty; returns cycles taken.
   task automatic drain(input string nm, output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", nm, exp_q.size(), cyc);
      end
   endtask

   // Monitor / scoreboard
   logic        hold;
   logic [17:0] held;
   logic [17:0] act;
   logic [17:0] e;
   initial hold = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         act = {l_last, l_data, m_last, m_data};
         chk("valid_lockstep", {31'd0, l_valid}, {31'd0, m_valid});
         if (hold) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data_last", {14'd0, act}, {14'd0, held});
         end
         if (m_valid && out_ready) begin
            n_xfer++;
            hold = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h with empty queue at %0t", act, $time);
            end else begin
               e = exp_q.pop_front();
               chk("byte", {14'd0, act}, {14'd0, e});
            end
         end else if (m_valid) begin
            hold = 1'b1;
            held = act;
         end else begin
            hold = 1'b0;
            chk("idle_outputs", {14'd0, act}, 32'd0);
         end
      end
   end

   // Stimulus
   int cyc;
   int x0;

   initial begin
      rst_n     = 1'b0;
      ct_in     = '0;
      ct_done   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data", {24'd0, m_data}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_ovf", {31'd0, m_ovf}, 32'd0);
      chk("rst_cnt", {30'd0, m_cnt}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single block, both byte orders, full rate
      out_ready = 1'b1;
      send_block(BLK_K, 1'b1);
      chk("single_valid_latency", {31'd0, m_valid}, 32'd1);
      chk("single_first_msb", {24'd0, m_data}, 32'h69);
      chk("single_first_lsb", {24'd0, l_data}, 32'h5a);
      chk("single_cnt", {30'd0, m_cnt}, 32'd1);
      drain("single", cyc);
      chk("single_cycles", cyc, 32'd16);
      chk("single_end_valid", {31'd0, m_valid}, 32'd0);
      chk("single_end_cnt", {30'd0, m_cnt}, 32'd0);

      // Backpressure: out_ready pattern 1,0,0 repeating
      x0 = n_xfer;
      out_ready = 1'b0;
      send_block(BLK_K, 1'b1);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         out_ready = (i % 3 == 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      chk("bp_queue_empty", exp_q.size(), 32'd0);
      chk("bp_transfers", n_xfer - x0, 32'd16);
      chk("bp_end_cnt", {30'd0, m_cnt}, 32'd0);

      // Simultaneous capture and pop on a full buffer
      send_block(BLK_A, 1'b1);
      send_block(BLK_B, 1'b1);
      chk("sim_full_cnt", {30'd0, m_cnt}, 32'd2);
      out_ready = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
      end
      chk("sim_head_last", {31'd0, m_last}, 32'd1);
      send_block(BLK_C, 1'b1);
      chk("sim_ovf_msb", {31'd0, m_ovf}, 32'd0);
      chk("sim_ovf_lsb", {31'd0, l_ovf}, 32'd0);
      chk("sim_cnt", {30'd0, m_cnt}, 32'd2);
      drain("sim", cyc);
      chk("sim_cycles", cyc, 32'd32);
      chk("sim_end_cnt", {30'd0, m_cnt}, 32'd0);

      // Fill and overflow: A, B captured, C dropped
      out_ready = 1'b0;
      send_block(BLK_A, 1'b1);
      send_block(BLK_B, 1'b1);
      send_block(BLK_C, 1'b0);
      chk("fill_cnt", {30'd0, m_cnt}, 32'd2);
      chk("fill_ovf_msb", {31'd0, m_ovf}, 32'd1);
      chk("fill_ovf_lsb", {31'd0, l_ovf}, 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("fill_hold_cnt", {30'd0, m_cnt}, 32'd2);
      chk("fill_hold_first", {24'd0, m_data}, 32'h00);
      out_ready = 1'b1;
      drain("fill", cyc);
      chk("fill_cycles", cyc, 32'd32);
      chk("fill_end_valid", {31'd0, m_valid}, 32'd0);
      chk("fill_ovf_sticky", {31'd0, m_ovf}, 32'd1);

      // Reset mid-stream after 5 bytes
      send_block(BLK_K, 1'b1);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_mid_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_mid_last", {31'd0, m_last}, 32'd0);
      chk("rst_mid_cnt", {30'd0, m_cnt}, 32'd0);
      chk("rst_mid_ovf", {31'd0, m_ovf}, 32'd0);
      chk("rst_mid_data", {24'd0, m_data}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_block(BLK_B, 1'b1);
      chk("post_rst_first", {24'd0, m_data}, 32'hf0);
      chk("post_rst_first_lsb", {24'd0, l_data}, 32'h0f);
      drain("post_rst", cyc);
      chk("post_rst_cycles", cyc, 32'd16);
      chk("post_rst_cnt", {30'd0, m_cnt}, 32'd0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
